// File: rtl/gb_bus_responder_if.sv
// CPU-side bus and external memory port of the Game Boy bus responder.
// The responder connects through the slave modport; a CPU/memory model uses master.
interface gb_bus_responder_if;
    logic [1:0]  bus_op_i;
    logic [15:0] addr_i;
    logic [7:0]  dout_i;
    logic [7:0]  din_o;
    logic        ready_o;
    logic        fetch_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;

    modport slave (
        input  bus_op_i, addr_i, dout_i, mem_rdata_i, mem_ack_i,
        output din_o, ready_o, fetch_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output bus_op_i, addr_i, dout_i, mem_rdata_i, mem_ack_i,
        input  din_o, ready_o, fetch_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/gb_bus_responder.sv
// Game Boy CPU bus responder: runs T1-T2-T3-(WAIT)-T4 M-cycles, serves IE and HRAM
// internally and forwards everything else to an external ack-based memory port.
module gb_bus_responder #(
    parameter int TIMEOUT = 15,
    parameter bit HRAM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    gb_bus_responder_if.slave bus,
    output logic              timeout_o,
    output logic [7:0]        ie_o
);
    localparam logic [1:0] OP_IDLE   = 2'd0;
    localparam logic [1:0] OP_IF     = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] OP_READ   = 2'd3;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3, S_WAIT = 3'd4, S_T4 = 3'd5
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  op_r, op_s;
    logic [15:0] addr_r, addr_s;
    logic [7:0]  wdata_r, wdata_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;
    logic [7:0]  rdata_r, rdata_s;
    logic [7:0]  din_r, din_s;
    logic        ready_r, ready_s;
    logic        fetch_r, fetch_s;
    logic        timeout_r, timeout_s;
    logic [7:0]  ie_r, ie_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic [15:0] mem_addr_r, mem_addr_s;
    logic [7:0]  mem_wdata_r, mem_wdata_s;

    logic        ack_hit_s, ie_hit_s, hram_hit_s, is_read_s;
    logic [7:0]  hram_rd_s;
    logic [7:0]  hram [0:126];

    assign ie_hit_s   = (addr_r == 16'hFFFF);
    assign hram_hit_s = HRAM_EN && (addr_r >= 16'hFF80) && (addr_r <= 16'hFFFE);
    assign is_read_s  = (op_r == OP_READ) || (op_r == OP_IF);
    assign hram_rd_s  = hram[addr_r[6:0]];
    // mem_req_r is only high between T2 entry and ack/timeout, so it gates stray acks
    assign ack_hit_s  = mem_req_r && bus.mem_ack_i &&
                        ((state_r == S_T2) || (state_r == S_T3) || (state_r == S_WAIT));

    // Next-state and next-output logic for the M-cycle sequencer
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        wait_cnt_s  = wait_cnt_r;
        din_s       = din_r;
        timeout_s   = timeout_r;
        ie_s        = ie_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        ready_s     = 1'b0;
        fetch_s     = 1'b0;

        if (ack_hit_s) begin
            mem_req_s = 1'b0;
            mem_we_s  = 1'b0;
            rdata_s   = bus.mem_rdata_i;
        end else begin
            rdata_s   = rdata_r;
        end

        case (state_r)
            S_IDLE, S_T4: begin
                if (bus.bus_op_i != OP_IDLE) begin
                    state_s = S_T1;
                    op_s    = bus.bus_op_i;
                    addr_s  = bus.addr_i;
                    wdata_s = bus.dout_i;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_T1: begin
                state_s    = S_T2;
                wait_cnt_s = 8'd0;
                if (!ie_hit_s && !hram_hit_s) begin
                    mem_req_s   = 1'b1;
                    mem_we_s    = (op_r == OP_WRITE);
                    mem_addr_s  = addr_r;
                    mem_wdata_s = wdata_r;
                end else begin
                    mem_req_s   = 1'b0;
                end
            end
            S_T2: begin
                state_s = S_T3;
            end
            S_T3: begin
                if (!ie_hit_s && !hram_hit_s) begin
                    if (ack_hit_s || !mem_req_r) begin
                        state_s = S_T4;
                    end else begin
                        state_s = S_WAIT;
                    end
                end else begin
                    state_s = S_T4;
                    if (is_read_s) begin
                        rdata_s = ie_hit_s ? ie_r : hram_rd_s;
                    end else if (ie_hit_s) begin
                        ie_s = wdata_r;
                    end else begin
                        ie_s = ie_r;
                    end
                end
            end
            S_WAIT: begin
                if (ack_hit_s) begin
                    state_s = S_T4;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s   = S_T4;
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    timeout_s = 1'b1;
                    rdata_s   = 8'hFF;
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        ready_s = (state_s == S_T4);
        fetch_s = (state_s != S_IDLE) && (op_s == OP_IF);
        if (ready_s && is_read_s) begin
            din_s = rdata_s;
        end else begin
            din_s = din_r;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            op_r        <= OP_IDLE;
            addr_r      <= 16'h0000;
            wdata_r     <= 8'h00;
            wait_cnt_r  <= 8'd0;
            rdata_r     <= 8'hFF;
            din_r       <= 8'hFF;
            ready_r     <= 1'b0;
            fetch_r     <= 1'b0;
            timeout_r   <= 1'b0;
            ie_r        <= 8'h00;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            wait_cnt_r  <= wait_cnt_s;
            rdata_r     <= rdata_s;
            din_r       <= din_s;
            ready_r     <= ready_s;
            fetch_r     <= fetch_s;
            timeout_r   <= timeout_s;
            ie_r        <= ie_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // HRAM write port; deliberately not reset so contents survive an aborted M-cycle
    always_ff @(posedge clk) begin
        if (!reset && (state_r == S_T3) && hram_hit_s && (op_r == OP_WRITE)) begin
            hram[addr_r[6:0]] <= wdata_r;
        end
    end

    assign bus.din_o       = din_r;
    assign bus.ready_o     = ready_r;
    assign bus.fetch_o     = fetch_r;
    assign bus.mem_req_o   = mem_req_r;
    assign bus.mem_we_o    = mem_we_r;
    assign bus.mem_addr_o  = mem_addr_r;
    assign bus.mem_wdata_o = mem_wdata_r;
    assign timeout_o       = timeout_r;
    assign ie_o            = ie_r;
endmodule
